ins_wb_arbiter: RTL and testbench

- Shares the single register-file write port among NUM_REQ execution units. Requesters are the RV32I R-type, I-type, load and CSR exec units; each drives an op/idx/val write-back triple.
- Each requester owns a one-entry holding buffer. Pending entries are granted round-robin, one register write per cycle.
- Sits between the exec units and the register file write port. The exec units themselves are combinational.

---
 rtl/ins_wb_arbiter_pkg.sv | 16 +
 rtl/ins_wb_arbiter_if.sv | 30 +++
 rtl/ins_wb_arbiter_rr_arbiter.sv | 36 +++
 rtl/ins_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_ins_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ins_wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: default widths, the x0
// register index and the round-robin pointer wrap helper.
package ins_wb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_IDX_W  = 5;

   // Writes to x0 are architecturally discarded
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Round-robin successor of requester g among n requesters
   function automatic int rr_next(input int g, input int n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/ins_wb_arbiter_if.sv
// Write-back bus between the exec units / register file and the arbiter.
// master: exec-unit and register-file side; slave: the arbiter.
interface ins_wb_arbiter_if
   import ins_wb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int IDX_W   = DEF_IDX_W
);

   logic [NUM_REQ-1:0]        req_w_op;
   logic [NUM_REQ*IDX_W-1:0]  req_w_reg_idx;
   logic [NUM_REQ*DATA_W-1:0] req_w_reg_val;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      reg_w_op;
   logic [IDX_W-1:0]          reg_w_reg_idx;
   logic [DATA_W-1:0]         reg_w_reg_val;
   logic                      busy;

   modport master (
      output req_w_op, req_w_reg_idx, req_w_reg_val,
      input  req_ready, reg_w_op, reg_w_reg_idx, reg_w_reg_val, busy
   );

   modport slave (
      input  req_w_op, req_w_reg_idx, req_w_reg_val,
      output req_ready, reg_w_op, reg_w_reg_idx, reg_w_reg_val, busy
   );

endinterface

// File: rtl/ins_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after
// ptr (wrapping) wins. Produces one-hot and encoded grant.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               any_grant
);

   int               pos;
   logic [PTR_W-1:0] slot;

   // Scan requesters starting at ptr; the first pending one takes the grant
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      pos       = 0;
      slot      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         slot = PTR_W'(pos);
         if (!any_grant && req[slot]) begin
            any_grant   = 1'b1;
            grant[slot] = 1'b1;
            grant_idx   = slot;
         end
      end
   end

endmodule

// File: rtl/ins_wb_arbiter.sv
// Register-file write-back arbiter. Each requester has a one-entry holding
// buffer; pending entries are granted round-robin, one write per cycle.
// Optional macro INS_WB_ARB_BYPASS_EN lets a live request compete directly
// and be written without buffering (one-cycle uncontended latency).
module ins_wb_arbiter
   import ins_wb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic        clk,
   input  logic        rst_n,
   ins_wb_arbiter_if.slave bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] pend;
   logic [IDX_W-1:0]   buf_idx [NUM_REQ];
   logic [DATA_W-1:0]  buf_val [NUM_REQ];
   logic [IDX_W-1:0]   in_idx  [NUM_REQ];
   logic [DATA_W-1:0]  in_val  [NUM_REQ];
   logic [PTR_W-1:0]   ptr;

   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] ready;
   logic [NUM_REQ-1:0] xfer;
   logic [NUM_REQ-1:0] live_grant;
   logic [PTR_W-1:0]   g;
   logic               any_grant;
   logic [IDX_W-1:0]   sel_idx;
   logic [DATA_W-1:0]  sel_val;
   logic               sel_wr;

   logic               wr_op;
   logic [IDX_W-1:0]   wr_idx;
   logic [DATA_W-1:0]  wr_val;

   // Split the packed requester buses into per-requester fields
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         in_idx[i] = bus.req_w_reg_idx[i*IDX_W +: IDX_W];
         in_val[i] = bus.req_w_reg_val[i*DATA_W +: DATA_W];
      end
   end

`ifdef INS_WB_ARB_BYPASS_EN
   // An empty buffer with a live request competes using the live data
   assign cand = pend | bus.req_w_op;
`else
   assign cand = pend;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req       (cand),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (g),
      .any_grant (any_grant)
   );

   // A granted buffer frees its slot this cycle, so it may accept again
   assign ready      = ~pend | grant;
   assign xfer       = bus.req_w_op & ready;
   // Grant on a requester with nothing buffered can only be a live bypass
   assign live_grant = grant & ~pend;

   assign sel_idx = pend[g] ? buf_idx[g] : in_idx[g];
   assign sel_val = pend[g] ? buf_val[g] : in_val[g];
   assign sel_wr  = any_grant && (sel_idx != IDX_W'(REG_ZERO));

   assign bus.req_ready     = ready;
   assign bus.busy          = |pend;
   assign bus.reg_w_op      = wr_op;
   assign bus.reg_w_reg_idx = wr_idx;
   assign bus.reg_w_reg_val = wr_val;

   // Pending flags: set on a buffered transfer, cleared when granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i] && !live_grant[i]) pend[i] <= 1'b1;
            else if (grant[i])             pend[i] <= 1'b0;
         end
      end
   end

   // Holding buffers load on every transfer that is not bypassed
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (xfer[i] && !live_grant[i]) begin
            buf_idx[i] <= in_idx[i];
            buf_val[i] <= in_val[i];
         end
      end
   end

   // Round-robin pointer moves past the winner on every grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (any_grant) begin
         ptr <= PTR_W'(rr_next(int'(g), NUM_REQ));
      end
   end

   // Register-file write port; x0 grants are consumed without a write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_op  <= 1'b0;
         wr_idx <= '0;
         wr_val <= '0;
      end else if (sel_wr) begin
         wr_op  <= 1'b1;
         wr_idx <= sel_idx;
         wr_val <= sel_val;
      end else begin
         wr_op  <= 1'b0;
         wr_idx <= '0;
         wr_val <= '0;
      end
   end

endmodule

// File: tb/tb_ins_wb_arbiter.sv
// Self-checking bench for ins_wb_arbiter: directed scenarios plus a random
// phase, all compared against a transaction-level reference model.
module tb_ins_wb_arbiter;
   import ins_wb_pkg::*;

   localparam int N = 4;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] val;
   } wr_t;

   logic clk;
   logic rst_n;

   ins_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .IDX_W(5)) bus ();

   ins_wb_arbiter #(.NUM_REQ(N), .DATA_W(32), .IDX_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Stimulus for the current cycle
   logic [N-1:0] d_op;
   logic [4:0]   d_idx [N];
   logic [31:0]  d_val [N];

   // Reference model state: each requester holds at most one waiting write
   logic [N-1:0] m_pend;
   wr_t          m_ent [N];
   int           m_ptr;
   wr_t          m_out;
   logic         m_out_vld;
   logic [N-1:0] m_acc;

   wr_t wlog [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pend    = '0;
      m_ptr     = 0;
      m_out     = '0;
      m_out_vld = 1'b0;
      m_acc     = '0;
   endtask

   task automatic check_regs();
      chk("w_op",  64'(bus.reg_w_op),      64'(m_out_vld));
      chk("w_idx", 64'(bus.reg_w_reg_idx), 64'(m_out.idx));
      chk("w_val", 64'(bus.reg_w_reg_val), 64'(m_out.val));
   endtask

   // One clock: drive inputs, check handshake, advance the model, check port
   task automatic cycle();
      logic [N-1:0] avail;
      logic [N-1:0] exp_ready;
      int           win;
      int           j;
      wr_t          w;
      logic         live;
      for (int i = 0; i < N; i++) begin
         bus.req_w_reg_idx[i*5 +: 5]   = d_idx[i];
         bus.req_w_reg_val[i*32 +: 32] = d_val[i];
      end
      bus.req_w_op = d_op;
      #1;
      avail = m_pend;
`ifdef INS_WB_ARB_BYPASS_EN
      avail = avail | d_op;
`endif
      win = -1;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (win < 0 && avail[j]) win = j;
      end
      for (int i = 0; i < N; i++) exp_ready[i] = !m_pend[i] || (win == i);
      chk("ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("busy",  64'(bus.busy),      64'(m_pend != '0));
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_reset();
      end else begin
         m_out = '0;
         m_out_vld = 1'b0;
         live = 1'b0;
         if (win >= 0) begin
            live = !m_pend[win];
            w = live ? wr_t'{d_idx[win], d_val[win]} : m_ent[win];
            if (w.idx != 5'd0) begin
               m_out = w;
               m_out_vld = 1'b1;
            end
            m_ptr = (win + 1) % N;
            m_pend[win] = 1'b0;
         end
         m_acc = d_op & exp_ready;
         for (int i = 0; i < N; i++) begin
            if (m_acc[i] && !(live && win == i)) begin
               m_pend[i] = 1'b1;
               m_ent[i]  = wr_t'{d_idx[i], d_val[i]};
            end
         end
      end
      check_regs();
      if (bus.reg_w_op === 1'b1) wlog.push_back(wr_t'{bus.reg_w_reg_idx, bus.reg_w_reg_val});
   endtask

   task automatic idle(input int n);
      d_op = '0;
      for (int c = 0; c < n; c++) cycle();
   endtask

   int   cnt1, cnt3;
   logic [31:0] v1, v3;
   logic [4:0]  exp_order [5];

   initial begin
      m_reset();
      d_op = '0;
      for (int i = 0; i < N; i++) begin
         d_idx[i] = '0;
         d_val[i] = '0;
      end

      // 1. Reset with random requests on the inputs
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         d_op = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            d_idx[i] = 5'($urandom);
            d_val[i] = $urandom;
         end
         cycle();
         chk("rst_ready", 64'(bus.req_ready), 64'hF);
         chk("rst_busy",  64'(bus.busy),      64'h0);
         chk("rst_op",    64'(bus.reg_w_op),  64'h0);
      end
      d_op = '0;
      rst_n = 1'b1;
      idle(3);
      chk("rst_nowrite", 64'(wlog.size()), 64'd0);

      // 2. Single write from requester 0
      wlog.delete();
      d_op = 4'b0001;
      d_idx[0] = 5'd5;
      d_val[0] = 32'h0000_1234;
      cycle();
      d_op = '0;
`ifdef INS_WB_ARB_BYPASS_EN
      chk("single_op",  64'(bus.reg_w_op),      64'h1);
      chk("single_idx", 64'(bus.reg_w_reg_idx), 64'd5);
      chk("single_val", 64'(bus.reg_w_reg_val), 64'h1234);
`else
      chk("single_early", 64'(bus.reg_w_op), 64'h0);
      cycle();
      chk("single_op",  64'(bus.reg_w_op),      64'h1);
      chk("single_idx", 64'(bus.reg_w_reg_idx), 64'd5);
      chk("single_val", 64'(bus.reg_w_reg_val), 64'h1234);
`endif
      idle(3);
      chk("single_count", 64'(wlog.size()), 64'd1);

      // 3. Round-robin: requester 2 alone, then all four at once
      wlog.delete();
      d_op = 4'b0100;
      d_idx[2] = 5'd2;
      d_val[2] = 32'h200;
      cycle();
      d_op = 4'b1111;
      for (int i = 0; i < N; i++) begin
         d_idx[i] = 5'(i + 1);
         d_val[i] = 32'h300 + 32'(i);
      end
      cycle();
      idle(6);
      exp_order[0] = 5'd2; exp_order[1] = 5'd4; exp_order[2] = 5'd1;
      exp_order[3] = 5'd2; exp_order[4] = 5'd3;
      chk("rr_count", 64'(wlog.size()), 64'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < wlog.size()) chk("rr_order", 64'(wlog[k].idx), 64'(exp_order[k]));
      end

      // 4. Streaming from requesters 1 and 3 under contention
      wlog.delete();
      v1 = 32'h10;
      v3 = 32'h30;
      for (int c = 0; c < 12; c++) begin
         d_op = 4'b1010;
         d_idx[1] = 5'd1; d_val[1] = v1;
         d_idx[3] = 5'd3; d_val[3] = v3;
         cycle();
         if (m_acc[1]) v1 = v1 + 1;
         if (m_acc[3]) v3 = v3 + 1;
      end
      idle(4);
      cnt1 = 0;
      cnt3 = 0;
      for (int k = 0; k < wlog.size(); k++) begin
         if (wlog[k].idx == 5'd1) begin
            chk("stream_val1", 64'(wlog[k].val), 64'(32'h10 + 32'(cnt1)));
            cnt1++;
         end else begin
            chk("stream_val3", 64'(wlog[k].val), 64'(32'h30 + 32'(cnt3)));
            cnt3++;
         end
         if (k > 0) chk("stream_alt", 64'(wlog[k].idx != wlog[k-1].idx), 64'h1);
      end
      chk("stream_cnt1", 64'(cnt1), 64'(v1 - 32'h10));
      chk("stream_cnt3", 64'(cnt3), 64'(v3 - 32'h30));

      // 5. Write to x0 is dropped but still advances the pointer
      wlog.delete();
      d_op = 4'b0001;
      d_idx[0] = 5'd0;
      d_val[0] = 32'hDEAD_BEEF;
      cycle();
      idle(2);
      chk("x0_nowrite", 64'(wlog.size()), 64'd0);
      chk("x0_ready0",  64'(bus.req_ready[0]), 64'h1);
      d_op = 4'b1111;
      for (int i = 0; i < N; i++) d_idx[i] = 5'(8 + i);
      cycle();
      idle(6);
      chk("x0_count", 64'(wlog.size()), 64'd4);
      if (wlog.size() == 4) begin
         chk("x0_first",  64'(wlog[0].idx), 64'd9);
         chk("x0_last",   64'(wlog[3].idx), 64'd8);
      end

      // 6. Reset pulse with writes pending
      d_op = 4'b0111;
      for (int i = 0; i < N; i++) begin
         d_idx[i] = 5'(20 + i);
         d_val[i] = 32'hA0 + 32'(i);
      end
      cycle();
      d_op = '0;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("mid_busy", 64'(bus.busy),     64'h0);
      chk("mid_op",   64'(bus.reg_w_op), 64'h0);
      cycle();
      rst_n = 1'b1;
      wlog.delete();
      idle(4);
      chk("mid_nowrite", 64'(wlog.size()), 64'd0);
      d_op = 4'b1111;
      cycle();
      idle(6);
      chk("mid_count", 64'(wlog.size()), 64'd4);
      if (wlog.size() == 4) chk("mid_ptr0", 64'(wlog[0].idx), 64'd20);

      // 7. Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         d_op = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            d_idx[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d_val[i] = $urandom;
         end
         cycle();
      end
      idle(6);
      chk("final_busy", 64'(bus.busy), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
